control_unit: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 55 +++++
 rtl/alu_op_decode.sv | 33 +++
 rtl/control_unit.sv | 140 ++++++++++++++
 tb/tb_control_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_ctrl_pkg : opcodes, sequencer states and control-word layout shared    |
// |                by control_unit and alu_op_decode.                          |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,
                         OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5,
                         OP_OR   = 5'd6,  OP_SHR  = 5'd7,  OP_SHL  = 5'd8,
                         OP_ROR  = 5'd9,  OP_ROL  = 5'd10, OP_ADDI = 5'd11,
                         OP_ANDI = 5'd12, OP_ORI  = 5'd13, OP_MUL  = 5'd14,
                         OP_DIV  = 5'd15, OP_NEG  = 5'd16, OP_NOT  = 5'd17,
                         OP_BR   = 5'd18, OP_JR   = 5'd19, OP_JAL  = 5'd20,
                         OP_IN   = 5'd21, OP_OUT  = 5'd22, OP_MFHI = 5'd23,
                         OP_MFLO = 5'd24, OP_NOP  = 5'd25, OP_HALT = 5'd26;

  // Bit positions inside the ALU strobe vector (MSB = AND ... LSB = IncPC).
  localparam int ALU_W     = 13;
  localparam int ALU_INCPC = 0,  ALU_NOT = 1,  ALU_NEG = 2,  ALU_ROL = 3,
                 ALU_ROR   = 4,  ALU_SHL = 5,  ALU_SHR = 6,  ALU_DIV = 7,
                 ALU_MUL   = 8,  ALU_SUB = 9,  ALU_ADD = 10, ALU_OR  = 11,
                 ALU_AND   = 12;

  typedef enum logic [3:0] {
    RESET = 4'd0, F0 = 4'd1, F1 = 4'd2, F2 = 4'd3, T3 = 4'd4,
    T4    = 4'd5, T5 = 4'd6, T6 = 4'd7, T7 = 4'd8, HALT = 4'd9
  } state_t;

  typedef struct packed {
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Inportout, Cout, BAout, Rout;
    logic Gra, Grb, Grc;
    logic Rin, PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin, OutPort;
    logic read, write;
    logic [ALU_W-1:0] alu;
  } ctrl_t;

  // Last state of each instruction; nop, jal and unknown opcodes end in F2.
  function automatic state_t final_state(input logic [4:0] op);
    state_t s;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:      s = T5;
      OP_NEG, OP_NOT:                        s = T4;
      OP_MUL, OP_DIV, OP_BR:                 s = T6;
      OP_LD, OP_ST:                          s = T7;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: s = T3;
      default:                               s = F2;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_op_decode : opcode to one-hot ALU strobe used in the operate state.    |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module alu_op_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0]       op_i,
  output logic [ALU_W-1:0] strobe_o
);

  always_comb begin
    strobe_o = '0;
    case (op_i)
      OP_ADD, OP_ADDI, OP_LDI, OP_LD, OP_ST: strobe_o[ALU_ADD] = 1'b1;
      OP_SUB:                                strobe_o[ALU_SUB] = 1'b1;
      OP_AND, OP_ANDI:                       strobe_o[ALU_AND] = 1'b1;
      OP_OR, OP_ORI:                         strobe_o[ALU_OR]  = 1'b1;
      OP_SHR:                                strobe_o[ALU_SHR] = 1'b1;
      OP_SHL:                                strobe_o[ALU_SHL] = 1'b1;
      OP_ROR:                                strobe_o[ALU_ROR] = 1'b1;
      OP_ROL:                                strobe_o[ALU_ROL] = 1'b1;
      OP_MUL:                                strobe_o[ALU_MUL] = 1'b1;
      OP_DIV:                                strobe_o[ALU_DIV] = 1'b1;
      OP_NEG:                                strobe_o[ALU_NEG] = 1'b1;
      OP_NOT:                                strobe_o[ALU_NOT] = 1'b1;
      default:                               strobe_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_unit : hardwired fetch/execute sequencer driving the datapath.     |
// |                Optional CU_MEM_WAIT_EN adds mem_ready stalls on memory     |
// |                states. Revision : 1.0                                      |
// +----------------------------------------------------------------------------+
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        con_ff,
  input  logic        stop,
`ifdef CU_MEM_WAIT_EN
  input  logic        mem_ready,
`endif
  output logic        run,
  output logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Inportout, Cout, BAout, Rout,
  output logic        Gra, Grb, Grc,
  output logic        Rin, PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin, OutPort,
  output logic        read, write,
  output logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC
);

  state_t           state_q, state_d;
  logic             stop_q, stop_d;
  ctrl_t            w_ctrl;
  logic [4:0]       w_op;
  logic [ALU_W-1:0] w_strobe;
  logic             w_advance;
  logic             w_unused_ir;

  assign w_op        = IR[31:27];
  assign w_unused_ir = ^IR[26:0];
  assign run         = (state_q != RESET) && (state_q != HALT);

  alu_op_decode u_alu_op_decode (
    .op_i     (w_op),
    .strobe_o (w_strobe)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= RESET;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    w_advance = 1'b1;
`ifdef CU_MEM_WAIT_EN
    if ((state_q == F1) || ((state_q == T6) && (w_op == OP_LD)) ||
        ((state_q == T7) && (w_op == OP_ST)))
      w_advance = mem_ready;
`endif
  end

  // A stop request seen mid-instruction is remembered until the final state.
  always_comb begin
    state_d = state_q;
    stop_d  = stop_q | (stop & run);
    case (state_q)
      RESET: state_d = F0;
      HALT:  state_d = HALT;
      default: begin
        if (!w_advance)                             state_d = state_q;
        else if ((state_q == F2) && (w_op == OP_HALT)) state_d = HALT;
        else if (state_q == final_state(w_op))       state_d = (stop_q || stop) ? HALT : F0;
        else                                         state_d = state_t'(state_q + 4'd1);
      end
    endcase
    if (state_d == HALT) stop_d = 1'b0;
  end

  always_comb begin
    w_ctrl = '0;
    case (state_q)
      F0: begin w_ctrl.PCout = 1'b1; w_ctrl.MARin = 1'b1; w_ctrl.alu[ALU_INCPC] = 1'b1; w_ctrl.Zin = 1'b1; end
      F1: begin w_ctrl.Zlowout = 1'b1; w_ctrl.PCin = 1'b1; w_ctrl.read = 1'b1; w_ctrl.MDRin = 1'b1; end
      F2: begin w_ctrl.MDRout = 1'b1; w_ctrl.IRin = 1'b1; end
      T3: case (w_op)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ADDI, OP_ANDI, OP_ORI:
                           begin w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Yin = 1'b1; end
        OP_LDI, OP_LD, OP_ST: begin w_ctrl.Grb = 1'b1; w_ctrl.BAout = 1'b1; w_ctrl.Yin = 1'b1; end
        OP_MUL, OP_DIV:    begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Yin = 1'b1; end
        OP_NEG, OP_NOT:    begin w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.alu = w_strobe; w_ctrl.Zin = 1'b1; end
        OP_BR:             begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; end
        OP_JR:             begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.PCin = 1'b1; end
        OP_IN:             begin w_ctrl.Inportout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
        OP_OUT:            begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.OutPort = 1'b1; end
        OP_MFHI:           begin w_ctrl.HIout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
        OP_MFLO:           begin w_ctrl.LOout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
        default: ;
      endcase
      T4: case (w_op)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL:
                           begin w_ctrl.Grc = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.alu = w_strobe; w_ctrl.Zin = 1'b1; end
        OP_ADDI, OP_ANDI, OP_ORI, OP_LDI, OP_LD, OP_ST:
                           begin w_ctrl.Cout = 1'b1; w_ctrl.alu = w_strobe; w_ctrl.Zin = 1'b1; end
        OP_MUL, OP_DIV:    begin w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.alu = w_strobe; w_ctrl.Zin = 1'b1; end
        OP_NEG, OP_NOT:    begin w_ctrl.Zlowout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
        OP_BR:             begin w_ctrl.PCout = 1'b1; w_ctrl.Yin = 1'b1; end
        default: ;
      endcase
      T5: case (w_op)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:
                           begin w_ctrl.Zlowout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
        OP_LD, OP_ST:      begin w_ctrl.Zlowout = 1'b1; w_ctrl.MARin = 1'b1; end
        OP_MUL, OP_DIV:    begin w_ctrl.Zlowout = 1'b1; w_ctrl.LOin = 1'b1; end
        OP_BR:             begin w_ctrl.Cout = 1'b1; w_ctrl.alu[ALU_ADD] = 1'b1; w_ctrl.Zin = 1'b1; end
        default: ;
      endcase
      T6: case (w_op)
        OP_LD:             begin w_ctrl.read = 1'b1; w_ctrl.MDRin = 1'b1; end
        OP_ST:             begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.MDRin = 1'b1; end
        OP_MUL, OP_DIV:    begin w_ctrl.Zhighout = 1'b1; w_ctrl.HIin = 1'b1; end
        OP_BR:             begin w_ctrl.Zlowout = 1'b1; w_ctrl.PCin = con_ff; end
        default: ;
      endcase
      T7: case (w_op)
        OP_LD:             begin w_ctrl.MDRout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
        OP_ST:             w_ctrl.write = 1'b1;
        default: ;
      endcase
      default: w_ctrl = '0;
    endcase
  end

  assign {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Inportout, Cout, BAout, Rout,
          Gra, Grb, Grc,
          Rin, PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin, OutPort,
          read, write,
          AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC} = w_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// tb_control_unit: per-cycle control-word vectors per instruction, compared
// through a scoreboard queue, plus stop/halt/clear corner sequences.
module tb_control_unit;

  typedef logic [38:0] cv_t;

  localparam cv_t M_INCPC = 39'd1 << 0,  M_NOT = 39'd1 << 1,  M_NEG = 39'd1 << 2,
                  M_ROL   = 39'd1 << 3,  M_ROR = 39'd1 << 4,  M_SHL = 39'd1 << 5,
                  M_SHR   = 39'd1 << 6,  M_DIV = 39'd1 << 7,  M_MUL = 39'd1 << 8,
                  M_SUB   = 39'd1 << 9,  M_ADD = 39'd1 << 10, M_OR  = 39'd1 << 11,
                  M_AND   = 39'd1 << 12, M_WRITE = 39'd1 << 13, M_READ = 39'd1 << 14,
                  M_OUTPORT = 39'd1 << 15, M_MDRIN = 39'd1 << 16, M_ZIN = 39'd1 << 17,
                  M_LOIN  = 39'd1 << 18, M_HIIN = 39'd1 << 19, M_YIN = 39'd1 << 20,
                  M_MARIN = 39'd1 << 21, M_IRIN = 39'd1 << 22, M_PCIN = 39'd1 << 23,
                  M_RIN   = 39'd1 << 24, M_GRC = 39'd1 << 25, M_GRB = 39'd1 << 26,
                  M_GRA   = 39'd1 << 27, M_ROUT = 39'd1 << 28, M_BAOUT = 39'd1 << 29,
                  M_COUT  = 39'd1 << 30, M_INPORTOUT = 39'd1 << 31, M_LOOUT = 39'd1 << 32,
                  M_HIOUT = 39'd1 << 33, M_MDROUT = 39'd1 << 34, M_ZLOWOUT = 39'd1 << 35,
                  M_ZHIGHOUT = 39'd1 << 36, M_PCOUT = 39'd1 << 37, M_RUN = 39'd1 << 38;

  localparam cv_t E_F0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam cv_t E_F1 = M_RUN | M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
  localparam cv_t E_F2 = M_RUN | M_MDROUT | M_IRIN;
  localparam cv_t E_WB = M_RUN | M_ZLOWOUT | M_GRA | M_RIN;
  localparam cv_t E_BA = M_RUN | M_GRB | M_BAOUT | M_YIN;
  localparam cv_t E_CA = M_RUN | M_COUT | M_ADD | M_ZIN;
  localparam cv_t E_AD = M_RUN | M_ZLOWOUT | M_MARIN;

  localparam logic [31:0] IR_ADD = 32'h1891_8000, IR_LD = 32'h0080_0055,
                          IR_HALT = 32'hD000_0000;

  logic clk = 1'b0;
  logic clear, con_ff, stop, mem_ready;
  logic [31:0] IR;
  logic run, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Inportout, Cout, BAout, Rout;
  logic Gra, Grb, Grc, Rin, PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin, OutPort;
  logic read, write, AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;
  cv_t  act;

  assign act = {run, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Inportout, Cout, BAout, Rout,
                Gra, Grb, Grc, Rin, PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin, OutPort,
                read, write, AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC};

  control_unit dut (
    .clk(clk), .clear(clear), .IR(IR), .con_ff(con_ff), .stop(stop),
`ifdef CU_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .run(run), .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Inportout(Inportout), .Cout(Cout), .BAout(BAout),
    .Rout(Rout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .PCin(PCin), .IRin(IRin),
    .MARin(MARin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .Zin(Zin), .MDRin(MDRin),
    .OutPort(OutPort), .read(read), .write(write), .AND(AND), .OR(OR), .ADD(ADD),
    .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL),
    .NEG(NEG), .NOT(NOT), .IncPC(IncPC)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [31:0]      ir;
    logic             con;
    int               len;
    logic [7:0][38:0] seq;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];
  cv_t  sb [$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string nm, input cv_t a, input cv_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic step(input string nm);
    cv_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, got %h expected entry", nm, act);
    end else begin
      e = sb.pop_front();
      check(nm, act, e);
    end
  endtask

  task automatic set_vec(input int k, input string nm, input logic [31:0] ir, input logic con,
                         input int len, input cv_t t3, input cv_t t4, input cv_t t5,
                         input cv_t t6, input cv_t t7);
    vecs[k].name = nm; vecs[k].ir = ir; vecs[k].con = con; vecs[k].len = len;
    vecs[k].seq[0] = E_F0; vecs[k].seq[1] = E_F1; vecs[k].seq[2] = E_F2;
    vecs[k].seq[3] = t3;   vecs[k].seq[4] = t4;   vecs[k].seq[5] = t5;
    vecs[k].seq[6] = t6;   vecs[k].seq[7] = t7;
  endtask

  // Enters each instruction from F0; IR changes only while F0 is showing.
  task automatic run_vec(input int k);
    for (int i = 0; i < vecs[k].len; i++) sb.push_back(vecs[k].seq[i]);
    for (int i = 0; i < vecs[k].len; i++) begin
      step($sformatf("%s_c%0d", vecs[k].name, i));
      if (i == 0) begin
        IR = vecs[k].ir;
        con_ff = vecs[k].con;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; IR = '0; con_ff = 1'b0; stop = 1'b0; mem_ready = 1'b1;

    set_vec(0,  "add",   IR_ADD, 1'b0, 6, M_RUN|M_GRB|M_ROUT|M_YIN, M_RUN|M_GRC|M_ROUT|M_ADD|M_ZIN, E_WB, '0, '0);
    set_vec(1,  "ld",    IR_LD, 1'b0, 8, E_BA, E_CA, E_AD, M_RUN|M_READ|M_MDRIN, M_RUN|M_MDROUT|M_GRA|M_RIN);
    set_vec(2,  "st",    32'h1080_0087, 1'b0, 8, E_BA, E_CA, E_AD, M_RUN|M_GRA|M_ROUT|M_MDRIN, M_RUN|M_WRITE);
    set_vec(3,  "br_c0", 32'h9100_0014, 1'b0, 7, M_RUN|M_GRA|M_ROUT, M_RUN|M_PCOUT|M_YIN, E_CA, M_RUN|M_ZLOWOUT, '0);
    set_vec(4,  "br_c1", 32'h9100_0014, 1'b1, 7, M_RUN|M_GRA|M_ROUT, M_RUN|M_PCOUT|M_YIN, E_CA, M_RUN|M_ZLOWOUT|M_PCIN, '0);
    set_vec(5,  "neg",   32'h8000_0000, 1'b0, 5, M_RUN|M_GRB|M_ROUT|M_NEG|M_ZIN, E_WB, '0, '0, '0);
    set_vec(6,  "mul",   32'h7000_0000, 1'b0, 7, M_RUN|M_GRA|M_ROUT|M_YIN, M_RUN|M_GRB|M_ROUT|M_MUL|M_ZIN,
            M_RUN|M_ZLOWOUT|M_LOIN, M_RUN|M_ZHIGHOUT|M_HIIN, '0);
    set_vec(7,  "andi",  32'h6000_0000, 1'b0, 6, M_RUN|M_GRB|M_ROUT|M_YIN, M_RUN|M_COUT|M_AND|M_ZIN, E_WB, '0, '0);
    set_vec(8,  "mfhi",  32'hB800_0000, 1'b0, 4, M_RUN|M_HIOUT|M_GRA|M_RIN, '0, '0, '0, '0);
    set_vec(9,  "out",   32'hB000_0000, 1'b0, 4, M_RUN|M_GRA|M_ROUT|M_OUTPORT, '0, '0, '0, '0);
    set_vec(10, "nop",   32'hC800_0000, 1'b0, 3, '0, '0, '0, '0, '0);
    set_vec(11, "ror",   32'h4800_0000, 1'b0, 6, M_RUN|M_GRB|M_ROUT|M_YIN, M_RUN|M_GRC|M_ROUT|M_ROR|M_ZIN, E_WB, '0, '0);
    set_vec(12, "jr",    32'h9800_0000, 1'b0, 4, M_RUN|M_GRA|M_ROUT|M_PCIN, '0, '0, '0, '0);

    repeat (2) @(negedge clk);
    check("reset_state", act, '0);
    clear = 1'b0;

    for (int k = 0; k < NVEC; k++) run_vec(k);

    // stop pulsed for one cycle in T4 of add: halts after T5
    sb.push_back(E_F0); sb.push_back(E_F1); sb.push_back(E_F2);
    sb.push_back(vecs[0].seq[3]); sb.push_back(vecs[0].seq[4]); sb.push_back(vecs[0].seq[5]);
    sb.push_back('0); sb.push_back('0);
    for (int i = 0; i < 8; i++) begin
      step($sformatf("stop_c%0d", i));
      if (i == 0) IR = IR_ADD;
      if (i == 4) stop = 1'b1;
      if (i == 5) stop = 1'b0;
    end

    // clear out of HALT, then a halt instruction
    clear = 1'b1;
    #1 check("clear_in_halt", act, '0);
    @(negedge clk);
    clear = 1'b0;
    sb.push_back(E_F0); sb.push_back(E_F1); sb.push_back(E_F2);
    sb.push_back('0); sb.push_back('0);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("halt_c%0d", i));
      if (i == 0) IR = IR_HALT;
    end

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;

    // clear in ld T6 drops every output immediately
    for (int i = 0; i < 7; i++) sb.push_back(vecs[1].seq[i]);
    for (int i = 0; i < 7; i++) begin
      step($sformatf("ldclr_c%0d", i));
      if (i == 0) IR = IR_LD;
    end
    clear = 1'b1;
    #1 check("clear_ld_t6", act, '0);
    @(negedge clk);
    check("clear_held", act, '0);
    clear = 1'b0;
    sb.push_back(E_F0);
    step("after_clear_f0");

`ifdef CU_MEM_WAIT_EN
    IR = IR_ADD;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back(E_F1);
    sb.push_back(E_F2);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("memwait_c%0d", i));
      if (i == 2) mem_ready = 1'b1;
    end
`endif

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
